// File: rtl/mcu_reset_sequencer_pkg.sv
// Shared state encoding and default timing constants for the MCU reset sequencer.
package mcu_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_VIDEO     = 3'd2,
        S_RUN       = 3'd3,
        S_SOFT      = 3'd4
    } seq_state_t;

    localparam int DEF_DEB_CYCLES  = 500000;
    localparam int DEF_LOCK_CYCLES = 1000;
    localparam int DEF_VIDEO_DLY   = 50000;
    localparam int DEF_SOFT_PULSE  = 64;
    localparam int DEF_HB_BIT      = 24;

endpackage

// File: rtl/mcu_btn_debounce.sv
// Soft-button synchroniser + stability debounce; registered one-cycle falling-edge strobe.
// Strobe lags the raw pin by 2 sync cycles + DEB_CYCLES + 1; no backpressure.
module mcu_btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic CLK50M,
    input  logic sys_rstn,
    input  logic btn_raw,
    output logic btn_fall
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          btn_meta;
    logic          btn_sync;
    logic          btn_deb;
    logic [CW-1:0] deb_cnt;

    // The counter only runs while the synced level disagrees with the debounced level,
    // so any return to the debounced level restarts the stability window.
    always_ff @(posedge CLK50M) begin
        if (!sys_rstn) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_deb  <= 1'b1;
            btn_fall <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
            btn_fall <= 1'b0;
            if (btn_sync == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt  <= '0;
                btn_deb  <= btn_sync;
                btn_fall <= btn_deb;
            end else begin
                deb_cnt <= deb_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mcu_reset_sequencer.sv
// Ordered reset release (video/DDR first, CPU second), soft-reset pulse and heartbeat LED.
// All outputs registered; lock loss re-asserts resets one cycle after the synced lock drops.
module mcu_reset_sequencer
    import mcu_reset_sequencer_pkg::*;
#(
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int VIDEO_DLY   = DEF_VIDEO_DLY,
    parameter int SOFT_PULSE  = DEF_SOFT_PULSE,
    parameter int HB_BIT      = DEF_HB_BIT
) (
    input  logic       CLK50M,
    input  logic       sys_rstn,
    input  logic       pll_lock_i,
    input  logic       soft_btn_i,
    output logic       video_rstn,
    output logic       cpu_resetn,
    output logic       cpu_soft_resetn,
    output logic       pps_led,
    output logic [2:0] seq_state
);

    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int DW = $clog2(VIDEO_DLY + 1);
    localparam int PW = $clog2(SOFT_PULSE + 1);
    localparam int HW = HB_BIT + 1;
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_CYCLES - 1);
    localparam logic [DW-1:0] DLY_LAST   = DW'(VIDEO_DLY - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(SOFT_PULSE - 1);

    seq_state_t    state;
    logic          lock_meta;
    logic          lock_s;
    logic          btn_fall;
    logic [LW-1:0] lock_cnt;
    logic [DW-1:0] dly_cnt;
    logic [PW-1:0] pulse_cnt;
    logic [HW-1:0] hb_cnt;

    mcu_btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_debounce (
        .CLK50M   (CLK50M),
        .sys_rstn (sys_rstn),
        .btn_raw  (soft_btn_i),
        .btn_fall (btn_fall)
    );

    always_ff @(posedge CLK50M) begin
        if (!sys_rstn) begin
            state           <= S_HOLD;
            lock_meta       <= 1'b0;
            lock_s          <= 1'b0;
            lock_cnt        <= '0;
            dly_cnt         <= '0;
            pulse_cnt       <= '0;
            hb_cnt          <= '0;
            video_rstn      <= 1'b0;
            cpu_resetn      <= 1'b0;
            cpu_soft_resetn <= 1'b1;
        end else begin
            lock_meta <= pll_lock_i;
            lock_s    <= lock_meta;
            hb_cnt    <= hb_cnt + HW'(1);
            // Lock loss wins over everything, including a same-cycle button strobe.
            if (!lock_s && (state inside {S_VIDEO, S_RUN, S_SOFT})) begin
                state           <= S_WAIT_LOCK;
                lock_cnt        <= '0;
                dly_cnt         <= '0;
                pulse_cnt       <= '0;
                video_rstn      <= 1'b0;
                cpu_resetn      <= 1'b0;
                cpu_soft_resetn <= 1'b1;
            end else begin
                case (state)
                    S_HOLD: state <= S_WAIT_LOCK;
                    S_WAIT_LOCK: begin
                        if (!lock_s) begin
                            lock_cnt <= '0;
                        end else if (lock_cnt == LOCK_LAST) begin
                            lock_cnt   <= '0;
                            video_rstn <= 1'b1;
                            state      <= S_VIDEO;
                        end else begin
                            lock_cnt <= lock_cnt + LW'(1);
                        end
                    end
                    S_VIDEO: begin
                        if (dly_cnt == DLY_LAST) begin
                            dly_cnt    <= '0;
                            cpu_resetn <= 1'b1;
                            state      <= S_RUN;
                        end else begin
                            dly_cnt <= dly_cnt + DW'(1);
                        end
                    end
                    S_RUN: begin
                        if (btn_fall) begin
                            pulse_cnt       <= '0;
                            cpu_soft_resetn <= 1'b0;
                            state           <= S_SOFT;
                        end
                    end
                    S_SOFT: begin
                        if (pulse_cnt == PULSE_LAST) begin
                            pulse_cnt       <= '0;
                            cpu_soft_resetn <= 1'b1;
                            state           <= S_RUN;
                        end else begin
                            pulse_cnt <= pulse_cnt + PW'(1);
                        end
                    end
                    default: state <= S_HOLD;
                endcase
            end
        end
    end

    assign seq_state = state;
    assign pps_led   = hb_cnt[HB_BIT];

endmodule

// File: tb/tb_mcu_reset_sequencer.sv
// Bench for mcu_reset_sequencer: directed scenarios with literal expectations, then
// randomized lock/button/reset traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_mcu_reset_sequencer;
    import mcu_reset_sequencer_pkg::*;

    localparam int DEB = 4, LOCK = 8, VDLY = 4, SOFTP = 3, HB = 3;

    logic       CLK50M     = 1'b0;
    logic       sys_rstn   = 1'b0;
    logic       pll_lock_i = 1'b1;
    logic       soft_btn_i = 1'b1;
    logic       video_rstn, cpu_resetn, cpu_soft_resetn, pps_led;
    logic [2:0] seq_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 CLK50M = ~CLK50M;

    mcu_reset_sequencer #(
        .DEB_CYCLES  (DEB),
        .LOCK_CYCLES (LOCK),
        .VIDEO_DLY   (VDLY),
        .SOFT_PULSE  (SOFTP),
        .HB_BIT      (HB)
    ) dut (
        .CLK50M          (CLK50M),
        .sys_rstn        (sys_rstn),
        .pll_lock_i      (pll_lock_i),
        .soft_btn_i      (soft_btn_i),
        .video_rstn      (video_rstn),
        .cpu_resetn      (cpu_resetn),
        .cpu_soft_resetn (cpu_soft_resetn),
        .pps_led         (pps_led),
        .seq_state       (seq_state)
    );

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK50M);
    endtask

    // Behavioural model: inputs reach the sequencer two edges late; the button must
    // disagree with its debounced level on DEB consecutive edges; resets follow the phase.
    seq_state_t mst = S_HOLD;
    bit   mvalid = 0;
    logic lk_d1, lk_d2, bt_d1, bt_d2, mdeb, fall_q;
    logic raw_win[$];
    int   lock_run, vid_age, soft_left, hb_edges;

    always @(posedge CLK50M) begin
        logic ls, raw, fl, all_diff;
        if (!sys_rstn) begin
            mvalid = 1; mst = S_HOLD;
            lk_d1 = 0; lk_d2 = 0; bt_d1 = 0; bt_d2 = 0;
            mdeb = 1; fall_q = 0; raw_win.delete();
            lock_run = 0; vid_age = 0; soft_left = 0; hb_edges = 0;
        end else begin
            ls = lk_d2; raw = bt_d2; fl = fall_q;
            lk_d2 = lk_d1; lk_d1 = pll_lock_i;
            bt_d2 = bt_d1; bt_d1 = soft_btn_i;
            hb_edges++;
            raw_win.push_back(raw);
            if (raw_win.size() > DEB) void'(raw_win.pop_front());
            fall_q = 0;
            if (raw_win.size() == DEB) begin
                all_diff = 1;
                foreach (raw_win[i]) if (raw_win[i] == mdeb) all_diff = 0;
                if (all_diff) begin
                    fall_q = mdeb;
                    mdeb   = !mdeb;
                    raw_win.delete();
                end
            end
            case (mst)
                S_HOLD: mst = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    lock_run = ls ? lock_run + 1 : 0;
                    if (lock_run == LOCK) begin mst = S_VIDEO; vid_age = 0; end
                end
                default: begin
                    if (!ls) begin
                        mst = S_WAIT_LOCK; lock_run = 0;
                    end else if (mst == S_VIDEO) begin
                        vid_age++;
                        if (vid_age == VDLY) mst = S_RUN;
                    end else if (mst == S_RUN) begin
                        if (fl) begin mst = S_SOFT; soft_left = SOFTP; end
                    end else begin
                        soft_left--;
                        if (soft_left == 0) mst = S_RUN;
                    end
                end
            endcase
        end
    end

    always @(negedge CLK50M) begin
        int exp_v, act_v;
        if (mvalid) begin
            exp_v = (int'(mst) << 4)
                  | ((mst inside {S_VIDEO, S_RUN, S_SOFT}) ? 8 : 0)
                  | ((mst inside {S_RUN, S_SOFT}) ? 4 : 0)
                  | ((mst != S_SOFT) ? 2 : 0)
                  | ((hb_edges / 8) % 2);
            act_v = int'({seq_state, video_rstn, cpu_resetn, cpu_soft_resetn, pps_led});
            check("cycle_model", act_v, exp_v);
        end
    end

    initial begin
        int e, lows, pulses, cpu_drop, bad, toggles, last;
        logic prevs, prevp;
        int pll_run, btn_run, rst_run;

        // 1: power-up release order
        cyc(5);
        check("reset_outputs",
              int'({seq_state, video_rstn, cpu_resetn, cpu_soft_resetn, pps_led}), 2);
        sys_rstn = 1;
        e = 0;
        do begin cyc(1); e++; end while (!video_rstn && e < 40);
        check("video_release_cycles", e, 10);
        do begin cyc(1); e++; end while (!cpu_resetn && e < 60);
        check("cpu_release_cycles", e, 14);
        check("soft_idle_high", int'(cpu_soft_resetn), 1);

        // 2: one-cycle lock glitch restarts the lock count
        sys_rstn = 0; cyc(5); sys_rstn = 1;
        e = 0;
        do begin
            cyc(1); e++;
            if (e == 5) pll_lock_i = 0;
            if (e == 6) pll_lock_i = 1;
        end while (!video_rstn && e < 40);
        check("glitch_video_release_cycles", e, 16);
        e = 0;
        do begin cyc(1); e++; end while (!cpu_resetn && e < 20);
        check("glitch_cpu_release_cycles", e, 4);

        // 3: held button gives one 3-cycle pulse
        soft_btn_i = 0; lows = 0; pulses = 0; cpu_drop = 0; prevs = cpu_soft_resetn;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (i == 9) soft_btn_i = 1;
            if (!cpu_soft_resetn) lows++;
            if (prevs && !cpu_soft_resetn) pulses++;
            if (!cpu_resetn) cpu_drop++;
            prevs = cpu_soft_resetn;
        end
        check("soft_pulse_width", lows, 3);
        check("soft_pulse_count", pulses, 1);
        check("cpu_held_during_soft", cpu_drop, 0);

        // 4: short bounce is rejected
        soft_btn_i = 0; lows = 0; bad = 0;
        for (int i = 0; i < 17; i++) begin
            cyc(1);
            if (i == 1) soft_btn_i = 1;
            if (!cpu_soft_resetn) lows++;
            if (seq_state != 3'd3) bad++;
        end
        check("bounce_no_pulse", lows, 0);
        check("bounce_state_run", bad, 0);

        // 5: lock loss during the soft pulse
        soft_btn_i = 0; e = 0;
        do begin cyc(1); e++; end while (cpu_soft_resetn && e < 20);
        check("soft_entered", int'(seq_state), 4);
        pll_lock_i = 0; soft_btn_i = 1; e = 0;
        do begin cyc(1); e++; end while (seq_state == 3'd4 && e < 8);
        check("lock_loss_latency", e, 3);
        check("lock_loss_outputs",
              int'({seq_state, video_rstn, cpu_resetn, cpu_soft_resetn}), 9);
        cyc(3); pll_lock_i = 1; e = 0;
        do begin cyc(1); e++; end while (!cpu_resetn && e < 40);
        check("relock_run", int'(seq_state), 3);

        // 6: heartbeat period, then reset in the middle of a soft pulse
        prevp = pps_led; toggles = 0; bad = 0; last = -1;
        for (int i = 0; i < 64; i++) begin
            cyc(1);
            if (pps_led != prevp) begin
                toggles++;
                if (last >= 0 && i - last != 8) bad++;
                last = i;
            end
            prevp = pps_led;
        end
        check("pps_toggles", toggles, 8);
        check("pps_interval", bad, 0);
        soft_btn_i = 0; e = 0;
        do begin cyc(1); e++; end while (cpu_soft_resetn && e < 20);
        soft_btn_i = 1; cyc(1);
        check("mid_pulse_low", int'(cpu_soft_resetn), 0);
        sys_rstn = 0; cyc(1);
        check("reset_mid_pulse",
              int'({seq_state, video_rstn, cpu_resetn, cpu_soft_resetn, pps_led}), 2);
        cyc(3); sys_rstn = 1;

        // Randomized traffic, checked every cycle by the model
        pll_run = 0; btn_run = 0; rst_run = 0;
        for (int i = 0; i < 4000; i++) begin
            cyc(1);
            if (rst_run > 0) rst_run--;
            else if ($urandom_range(0, 799) == 0) rst_run = $urandom_range(1, 4);
            sys_rstn = (rst_run == 0);
            if (pll_run > 0) pll_run--;
            else begin
                pll_lock_i = !pll_lock_i;
                pll_run = pll_lock_i ? $urandom_range(10, 300) : $urandom_range(0, 5);
            end
            if (btn_run > 0) btn_run--;
            else begin
                soft_btn_i = !soft_btn_i;
                btn_run = soft_btn_i ? $urandom_range(3, 60) : $urandom_range(0, 9);
            end
        end
        cyc(2);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
